// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the front end: architectural widths, the default
// reset vector, the canonical NOP encoding, the {pc, instr} entry carried
// through the fetch buffer, and a helper that forces a target onto a word
// boundary.
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clears the two low address bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory bus between the fetch unit (master) and memory (slave).
//   req    master->slave  fetch request
//   addr   master->slave  word-aligned fetch address, valid while req=1
//   gnt    slave->master  request accepted this cycle (req && gnt)
//   rvalid slave->master  response valid, one cycle after acceptance
//   rdata  slave->master  instruction word, valid with rvalid
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Instruction buffer of DEPTH {pc, instr} entries between fetch and decode.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       empties the buffer; wins over push and pop
//   push        write push_entry at the tail
//   push_entry  {pc, instr} to store
//   pop         drop the head entry
//   head        current head entry, taken straight from storage
//   count       number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // The head is read from registered storage only, so decode never sees a
  // combinational path from the memory response.
  assign head = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as all zeros until the
  // first instruction lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch with a single outstanding memory request,
// credit-based issue into a DEPTH-entry buffer, and redirect handling.
//   clk, rst_n      clock, asynchronous active-low reset
//   imem            instruction-memory bus (master side)
//   redirect_valid  branch/jump redirect; flushes and restarts fetch
//   redirect_pc     redirect target (low two bits ignored)
//   instr_valid     buffer head holds an instruction
//   instr, instr_pc buffer head instruction and its address
//   instr_ready     decode consumes the head when instr_valid && instr_ready
// ---------------------------------------------------------------------------
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_unit_if.master     imem,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             instr_valid,
  output logic [ILEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  input  logic             instr_ready
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            outstanding_next;
  logic            discard;
  logic            discard_next;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  int              occupancy;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Slots already committed: buffered entries plus the in-flight response,
  // minus the head decode is taking this cycle. Counting the pop lets a new
  // request go out while the buffer drains, which is what sustains one
  // instruction per cycle with only two entries.
  always_comb begin
    occupancy = int'(count) + int'(outstanding) - int'(pop);
  end

  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign imem.req    = rst_n && !redirect_valid && (occupancy < DEPTH);
  assign imem.addr   = pc;
  assign accept      = imem.req && imem.gnt;
  assign push        = imem.rvalid && outstanding && !discard && !redirect_valid;
  assign push_entry  = '{pc: req_pc, instr: imem.rdata};
  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // Next-state for the fetch pc and the in-flight bookkeeping. A redirect
  // overrides everything; a response that has not yet returned when the
  // redirect hits is marked for discard so it cannot reach the buffer.
  always_comb begin
    pc_next          = pc;
    outstanding_next = outstanding;
    discard_next     = discard;
    if (redirect_valid) begin
      pc_next          = align_pc(redirect_pc);
      outstanding_next = outstanding && !imem.rvalid;
      discard_next     = outstanding && !imem.rvalid;
    end else begin
      if (imem.rvalid && outstanding) begin
        outstanding_next = 1'b0;
        discard_next     = 1'b0;
      end
      if (accept) begin
        pc_next          = pc + XLEN'(4);
        outstanding_next = 1'b1;
      end
    end
  end

  // req_pc remembers which address the in-flight response belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      pc          <= pc_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (accept) begin
        req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit: a table of per-cycle inputs with
// hand-computed imem_req / imem_addr / instr_valid / instr_pc, plus reset
// checks before the table and after an asynchronous reset mid-fetch.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk            = 1'b0;
  logic        rst_n          = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        instr_ready    = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        gnt_drv      = 1'b0;
  logic        mem_rvalid   = 1'b0;
  logic [31:0] mem_rdata    = '0;
  logic        stray_rvalid = 1'b0;

  int checks = 0;
  int errors = 0;

  // ctl bits, MSB first: gnt, ready, redirect, expected req, expected valid
  typedef struct packed {
    logic [4:0]  ctl;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] ipc;
  } row_t;

  row_t rows [33];

  fetch_unit_if bus ();

  assign bus.gnt    = gnt_drv;
  assign bus.rvalid = mem_rvalid | stray_rvalid;
  assign bus.rdata  = stray_rvalid ? 32'hDEAD_BEEF : mem_rdata;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory contents: the three known words at 0x0/0x4/0x8, otherwise a
  // word derived from the address so every fetch is distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hFFC4_A303;
      32'h0000_0004: return 32'h0064_A423;
      32'h0000_0008: return 32'h0062_E233;
      default:       return a + 32'h1000_0000;
    endcase
  endfunction

  // Memory model: sample acceptance mid-cycle, answer for exactly the cycle
  // after the accepting edge.
  initial begin : memory_model
    logic        acc;
    logic [31:0] acc_addr;
    forever begin
      @(negedge clk);
      acc      = rst_n && bus.req && bus.gnt;
      acc_addr = bus.addr;
      @(posedge clk);
      #1;
      mem_rvalid = acc;
      mem_rdata  = acc ? mem_word(acc_addr) : 32'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic r, input logic rv,
                               input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    gnt_drv        = g;
    instr_ready    = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic checkRow(input int i, input row_t row);
    checkOutput($sformatf("c%0d imem_req", i), {31'b0, bus.req}, {31'b0, row.ctl[1]});
    checkOutput($sformatf("c%0d imem_addr", i), bus.addr, row.addr);
    checkOutput($sformatf("c%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, row.ctl[0]});
    if (row.ctl[0]) begin
      checkOutput($sformatf("c%0d instr_pc", i), instr_pc, row.ipc);
      checkOutput($sformatf("c%0d instr", i), instr, mem_word(row.ipc));
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " imem_req"}, {31'b0, bus.req}, 32'h0);
    checkOutput({tag, " imem_addr"}, bus.addr, 32'h0);
    checkOutput({tag, " instr_valid"}, {31'b0, instr_valid}, 32'h0);
    checkOutput({tag, " instr"}, instr, 32'h0);
    checkOutput({tag, " instr_pc"}, instr_pc, 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    // Startup stream, then a 5-cycle decode stall (c5..c9)
    rows[0]  = '{5'b11010, 32'h0, 32'h0000_0000, 32'h0};
    rows[1]  = '{5'b11010, 32'h0, 32'h0000_0004, 32'h0};
    rows[2]  = '{5'b11011, 32'h0, 32'h0000_0008, 32'h0000_0000};
    rows[3]  = '{5'b11011, 32'h0, 32'h0000_000C, 32'h0000_0004};
    rows[4]  = '{5'b11011, 32'h0, 32'h0000_0010, 32'h0000_0008};
    for (int i = 5; i < 10; i++) begin
      rows[i] = '{5'b10001, 32'h0, 32'h0000_0014, 32'h0000_000C};
    end
    rows[10] = '{5'b11011, 32'h0, 32'h0000_0014, 32'h0000_000C};
    rows[11] = '{5'b11011, 32'h0, 32'h0000_0018, 32'h0000_0010};
    rows[12] = '{5'b11011, 32'h0, 32'h0000_001C, 32'h0000_0014};
    // Redirect to 0x8, then grant withheld for 3 cycles
    rows[13] = '{5'b11101, 32'h0000_0008, 32'h0000_0020, 32'h0000_0018};
    for (int i = 14; i < 17; i++) begin
      rows[i] = '{5'b01010, 32'h0, 32'h0000_0008, 32'h0};
    end
    rows[17] = '{5'b11010, 32'h0, 32'h0000_0008, 32'h0};
    rows[18] = '{5'b11010, 32'h0, 32'h0000_000C, 32'h0};
    // Redirect to 0x102 while 0xC is in flight
    rows[19] = '{5'b11101, 32'h0000_0102, 32'h0000_0010, 32'h0000_0008};
    rows[20] = '{5'b11010, 32'h0, 32'h0000_0100, 32'h0};
    rows[21] = '{5'b11010, 32'h0, 32'h0000_0104, 32'h0};
    rows[22] = '{5'b11011, 32'h0, 32'h0000_0108, 32'h0000_0100};
    // Back-to-back redirects, the second one wins
    rows[23] = '{5'b11101, 32'h0000_0200, 32'h0000_010C, 32'h0000_0104};
    rows[24] = '{5'b11100, 32'h0000_0300, 32'h0000_0200, 32'h0};
    rows[25] = '{5'b11010, 32'h0, 32'h0000_0300, 32'h0};
    rows[26] = '{5'b11010, 32'h0, 32'h0000_0304, 32'h0};
    rows[27] = '{5'b11011, 32'h0, 32'h0000_0308, 32'h0000_0300};
    // Redirect to the top word (low bits set), fetch wraps to zero
    rows[28] = '{5'b11101, 32'hFFFF_FFFF, 32'h0000_030C, 32'h0000_0304};
    rows[29] = '{5'b11010, 32'h0, 32'hFFFF_FFFC, 32'h0};
    rows[30] = '{5'b11010, 32'h0, 32'h0000_0000, 32'h0};
    rows[31] = '{5'b11011, 32'h0, 32'h0000_0004, 32'hFFFF_FFFC};
    rows[32] = '{5'b11011, 32'h0, 32'h0000_0008, 32'h0000_0000};

    repeat (2) @(negedge clk);
    checkReset("por");

    for (int i = 0; i < 33; i++) begin
      applyStimulus(rows[i].ctl[4], rows[i].ctl[3], rows[i].ctl[2], rows[i].rpc);
      checkRow(i, rows[i]);
    end

    // Reset asserted while a response is in flight and the buffer is occupied
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    #1;
    checkReset("async");
    @(negedge clk);
    checkReset("held");
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    gnt_drv      = 1'b1;
    instr_ready  = 1'b1;
    stray_rvalid = 1'b1;
    @(negedge clk);
    checkOutput("rel0 imem_req", {31'b0, bus.req}, 32'h1);
    checkOutput("rel0 imem_addr", bus.addr, 32'h0);
    @(posedge clk);
    #1;
    stray_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("rel1 instr_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("rel1 imem_addr", bus.addr, 32'h4);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rel2 instr_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("rel2 instr_pc", instr_pc, 32'h0);
    checkOutput("rel2 instr", instr, 32'hFFC4_A303);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rel3 instr_pc", instr_pc, 32'h4);
    checkOutput("rel3 instr", instr, 32'h0064_A423);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
